instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the RV32I control/decode path.
- Accepts instruction fields over a valid/ready handshake (format, op, f3, f7 bit, rd, rs1, rs2, immediate) and packs them into a 32-bit RV32I instruction word.
- Writes each packed word sequentially into instruction memory through a simple write port.
- Used to load programs into the single-cycle core's instruction memory before release, and as the bench-side generator for decoder/control-unit regression.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory write port.
- DEPTH, 64, number of words that may be loaded; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart: address, count, err and state return to reset values.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_op  in  7  opcode bits [6:0].
- in_f3  in  3  funct3.
- in_f7  in  1  funct7 bit 5 (the only funct7 bit the control unit decodes).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate, sign-extended byte value (U: full upper value).
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  encoded instruction; meaningful only while mem_we=1.
- count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  count == DEPTH.
- err  out  1  sticky: an illegal bundle was rejected.
- err_code  out  2  first error: 1=illegal fmt, 2=imm out of range, 3=imm misaligned.

Behaviour:
- Reset/clear (clear is identical to reset for all state):
  - All outputs are 0, and the FSM is in IDLE.
  - Reset or clear asserted mid-operation aborts any pending write; the word is not written.
- FSM states: IDLE, WRITE, FULL.
- in_ready = (state==IDLE) & !clear & !reset. When clear and in_valid are asserted together, clear wins and the bundle is not accepted.
- Accept occurs when in_valid & in_ready at edge N:
  - The encoded word and the legality result are registered.
  - The FSM goes IDLE→WRITE.
- WRITE (cycle N+1), legal bundle:
  - mem_we=1, mem_addr=current address, mem_wdata=encoded word.
  - At the edge, address and count increment.
  - Next state is FULL if the new count == DEPTH, else IDLE.
- WRITE (cycle N+1), illegal bundle:
  - mem_we=0; address and count are unchanged.
  - err is set; err_code is latched only if err was previously 0.
  - Next state is IDLE.
- Throughput is one bundle per 2 cycles. in_ready is 0 during WRITE.
- FULL: in_ready=0 and full=1 until reset or clear. The address never wraps.
- Encoding:
  - R: {0,f7,00000, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}. When op=0010011 and f3∈{001,101}, the upper field becomes {0,f7,00000, imm[4:0]}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Legality checks, in priority order:
  1. fmt ≥ 6 → code 1.
  2. Range → code 2. I/S: imm must be sign-extendable from 12 bits (non-shift I); shift I: imm[31:5]=0. B: from 13 bits. J: from 21 bits. U: imm[11:0]=0.
  3. B/J imm[0]≠0 → code 3.
- Field inputs are sampled only at accept and may change freely afterwards.

Test Plan:
- addi x1,x0,5 (fmt1, op 0010011, f3 0, rd1, rs1 0, imm 5) after reset → cycle N+1: mem_we=1, addr 0, wdata 0x00500093; count=1.
- add x3,x1,x2 then sub (f7=1) back-to-back with in_valid held high → wdata 0x002081B3 at addr 0, then 0x402081B3 at addr 1; in_ready low in each WRITE cycle.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,-4 → 0xFE208EE3; jal x1,8 → 0x008000EF.
- beq with imm=3 → no mem_we, err=1, err_code=3, count unchanged. A following addi with imm=4096 → still rejected, err_code stays 3.
- DEPTH=4: load 4 legal words → full=1 after the 4th write, in_ready=0, and a 5th in_valid is ignored. Then clear → count=0, full=0, err=0, next word written at addr 0.
- reset asserted in the WRITE cycle → mem_we=0 in that cycle, count=0, state IDLE next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and sequential instruction-memory loader.
// Field bundles arrive over valid/ready, get packed into 32-bit words, and are
// written one per two cycles to consecutive word addresses. Illegal bundles are
// dropped and flagged through a sticky error with the first error code kept.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_f3,
  input  logic              in_f7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  localparam logic [1:0] CodeOk       = 2'd0;
  localparam logic [1:0] CodeBadFmt   = 2'd1;
  localparam logic [1:0] CodeRange    = 2'd2;
  localparam logic [1:0] CodeMisalign = 2'd3;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        code_q, code_d;

  logic        restart;
  logic        is_shift;
  logic        sext12, sext13, sext21;
  logic        range_ok;
  logic [31:0] enc_word;
  logic [1:0]  chk_code;

  assign restart = reset | clear;

  // Immediate shifts reuse the I layout with funct7 in the upper bits.
  assign is_shift = (in_op == 7'b0010011) && ((in_f3 == 3'b001) || (in_f3 == 3'b101));

  // Sign-extendable from N bits: all bits above N-2 equal the sign bit.
  assign sext12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sext13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sext21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // Pack the incoming fields according to the instruction format.
  always_comb begin
    enc_word = '0;
    case (in_fmt)
      FmtR: enc_word = {1'b0, in_f7, 5'b0, in_rs2, in_rs1, in_f3, in_rd, in_op};
      FmtI: begin
        if (is_shift) begin
          enc_word = {1'b0, in_f7, 5'b0, in_imm[4:0], in_rs1, in_f3, in_rd, in_op};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_op};
        end
      end
      FmtS: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_op};
      FmtB: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                        in_imm[4:1], in_imm[11], in_op};
      FmtU: enc_word = {in_imm[31:12], in_rd, in_op};
      FmtJ: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: enc_word = '0;
    endcase
  end

  // Legality check in priority order: format, immediate range, alignment.
  always_comb begin
    chk_code = CodeOk;
    range_ok = 1'b1;
    case (in_fmt)
      FmtI:    range_ok = is_shift ? (in_imm[31:5] == 27'd0) : sext12;
      FmtS:    range_ok = sext12;
      FmtB:    range_ok = sext13;
      FmtJ:    range_ok = sext21;
      FmtU:    range_ok = (in_imm[11:0] == 12'd0);
      default: range_ok = 1'b1;
    endcase
    if (in_fmt >= 3'd6) begin
      chk_code = CodeBadFmt;
    end else if (!range_ok) begin
      chk_code = CodeRange;
    end else if (((in_fmt == FmtB) || (in_fmt == FmtJ)) && in_imm[0]) begin
      chk_code = CodeMisalign;
    end
  end

  // Next-state, handshake and write-port control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    word_d     = word_q;
    code_d     = code_q;
    mem_we     = 1'b0;
    in_ready   = (state_q == StIdle) && !restart;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          word_d  = enc_word;
          code_d  = chk_code;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (code_q == CodeOk) begin
          // A reset or clear landing here cancels the write strobe.
          mem_we  = !restart;
          count_d = count_q + 1'b1;
          // Hold the address at its top value rather than wrapping.
          addr_d  = (&addr_q) ? addr_q : addr_q + 1'b1;
          state_d = (count_d == DepthCnt) ? StFull : StIdle;
        end else begin
          err_d = 1'b1;
          if (!err_q) begin
            err_code_d = code_q;
          end
          state_d = StIdle;
        end
      end
      StFull: state_d = StFull;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset and clear both restart the loader.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: address, count, error status and the captured word.
  always_ff @(posedge clk) begin
    if (restart) begin
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      word_q     <= '0;
      code_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      word_q     <= word_d;
      code_q     <= code_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? word_q : 32'd0;
  assign count     = count_q;
  assign full      = (count_q == DepthCnt);
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader built with DEPTH=4.
module tb_instr_encoder_loader;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_op = '0;
  logic [2:0]    in_f3 = '0;
  logic          in_f7 = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [1:0]    err_code;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] OpImm = 7'h13;
  localparam logic [6:0] OpReg = 7'h33;
  localparam logic [6:0] OpSt  = 7'h23;
  localparam logic [6:0] OpBr  = 7'h63;
  localparam logic [6:0] OpJal = 7'h6F;
  localparam logic [6:0] OpLui = 7'h37;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[6];

  instr_encoder_loader #(
    .ADDR_W(AW),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_op    (in_op),
    .in_f3    (in_f3),
    .in_f7    (in_f7),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .count    (count),
    .full     (full),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_op = op; in_f3 = f3; in_f7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Offer one bundle from IDLE; returns at the negedge of the WRITE cycle.
  task automatic put(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(fmt, op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_held: got %b want 0", in_ready); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if ({full, err, err_code} !== 4'b0) begin
      bad++; $display("FAIL rst_status: got %b want 0000", {full, err, err_code});
    end
  endtask

  task automatic test_addi();
    put(3'd1, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL addi_we: got %b want 1", mem_we); end
    total++; if (mem_addr !== 6'd0) begin bad++; $display("FAIL addi_addr: got %0d want 0", mem_addr); end
    total++; if (mem_wdata !== 32'h00500093) begin
      bad++; $display("FAIL addi_wdata: got %h want 00500093", mem_wdata);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL addi_ready: got %b want 0", in_ready); end
    step();
    total++; if (count !== 7'd1) begin bad++; $display("FAIL addi_count: got %0d want 1", count); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL addi_we_after: got %b want 0", mem_we); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    set_fields(3'd0, OpReg, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    step();
    total++; if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'h002081B3) begin
      bad++; $display("FAIL b2b_add: got we=%b a=%0d d=%h want we=1 a=0 d=002081B3",
                      mem_we, mem_addr, mem_wdata);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready0: got %b want 0", in_ready); end
    // Fields change while the first word is being written; valid stays high.
    in_f7 = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got rdy=%b we=%b want rdy=1 we=0", in_ready, mem_we);
    end
    step();
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_wdata !== 32'h402081B3) begin
      bad++; $display("FAIL b2b_sub: got we=%b a=%0d d=%h want we=1 a=1 d=402081B3",
                      mem_we, mem_addr, mem_wdata);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready1: got %b want 0", in_ready); end
    step();
    total++; if (count !== 7'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", count); end
  endtask

  task automatic test_formats();
    vecs[0] = '{3'd2, OpSt,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423};
    vecs[1] = '{3'd3, OpBr,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3};
    vecs[2] = '{3'd5, OpJal, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF};
    vecs[3] = '{3'd4, OpLui, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7};
    vecs[4] = '{3'd1, OpImm, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3,        32'h00311093};
    vecs[5] = '{3'd1, OpImm, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        32'h40315093};
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) do_clear();
      put(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1,
          vecs[i].rs2, vecs[i].imm);
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 6'(i % 3) || mem_wdata !== vecs[i].word) begin
        bad++; $display("FAIL fmt_vec%0d: got we=%b a=%0d d=%h want we=1 a=%0d d=%h",
                        i, mem_we, mem_addr, mem_wdata, i % 3, vecs[i].word);
      end
      step();
    end
    total++; if (count !== 7'd3 || err !== 1'b0) begin
      bad++; $display("FAIL fmt_count: got cnt=%0d err=%b want cnt=3 err=0", count, err);
    end
  endtask

  task automatic test_errors();
    do_clear();
    put(3'd3, OpBr, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL err_mis_we: got %b want 0", mem_we); end
    step();
    total++; if (err !== 1'b1 || err_code !== 2'd3 || count !== 7'd0) begin
      bad++; $display("FAIL err_mis: got err=%b code=%0d cnt=%0d want 1 3 0", err, err_code, count);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL err_ready: got %b want 1", in_ready); end
    put(3'd1, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL err_rng_we: got %b want 0", mem_we); end
    step();
    total++; if (err !== 1'b1 || err_code !== 2'd3 || count !== 7'd0) begin
      bad++; $display("FAIL err_sticky: got err=%b code=%0d cnt=%0d want 1 3 0", err, err_code, count);
    end
    do_clear();
    put(3'd6, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    step();
    total++; if (err_code !== 2'd1) begin bad++; $display("FAIL err_fmt: got %0d want 1", err_code); end
    do_clear();
    put(3'd5, OpJal, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000);
    step();
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL err_jrange: got %0d want 2", err_code); end
    do_clear();
    put(3'd1, OpImm, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd32);
    step();
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL err_shamt: got %0d want 2", err_code); end
    do_clear();
    put(3'd4, OpLui, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345001);
    step();
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL err_urange: got %0d want 2", err_code); end
    do_clear();
    put(3'd5, OpJal, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    step();
    total++; if (err_code !== 2'd3) begin bad++; $display("FAIL err_jmis: got %0d want 3", err_code); end
    do_clear();
    put(3'd1, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'h80000093) begin
      bad++; $display("FAIL err_minimm: got we=%b d=%h want we=1 d=80000093", mem_we, mem_wdata);
    end
    step();
  endtask

  task automatic test_full();
    do_clear();
    put(3'd7, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      put(3'd1, OpImm, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== ((32'(i) << 20) | (32'(i + 1) << 7) | 32'h13)) begin
        bad++; $display("FAIL full_wr%0d: got we=%b a=%0d d=%h", i, mem_we, mem_addr, mem_wdata);
      end
      step();
    end
    total++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 7'd4) begin
      bad++; $display("FAIL full_state: got full=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count);
    end
    in_valid = 1'b1;
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL full_ign_we: got %b want 0", mem_we); end
    step();
    total++; if (mem_we !== 1'b0 || count !== 7'd4) begin
      bad++; $display("FAIL full_ign: got we=%b cnt=%0d want 0 4", mem_we, count);
    end
    clear = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", in_ready); end
    step();
    total++; if (count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin
      bad++; $display("FAIL clr_state: got cnt=%0d full=%b err=%b code=%0d want 0 0 0 0",
                      count, full, err, err_code);
    end
    // Still clearing from IDLE with valid high: the bundle must not be taken.
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL clr_wins: got we=%b want 0", mem_we); end
    clear = 1'b0;
    in_valid = 1'b0;
    put(3'd1, OpImm, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    total++; if (mem_we !== 1'b1 || mem_addr !== 6'd0) begin
      bad++; $display("FAIL clr_restart: got we=%b a=%0d want 1 0", mem_we, mem_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    put(3'd1, OpImm, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1);
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmw_we: got %b want 0", mem_we); end
    step();
    reset = 1'b0;
    #1;
    total++; if (count !== '0 || mem_addr !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rmw_state: got cnt=%0d a=%0d rdy=%b want 0 0 1", count, mem_addr, in_ready);
    end
    step();
    total++; if (mem_we !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL rmw_idle: got we=%b cnt=%0d want 0 0", mem_we, count);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_formats();
    test_errors();
    test_full();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
